// File: rtl/one_unit_iter_controller.sv
// FastICA fixed-point loop sequencer: one-unit pass, normalise, convergence check.
// Optional RUN watchdog enabled by defining ONE_UNIT_ITER_WATCHDOG_EN.
module one_unit_iter_controller #(
  parameter int                   MAX_ITER    = 16,
  parameter int                   ITER_W      = 5,
  parameter int                   METRIC_W    = 16,
  parameter logic [METRIC_W-1:0]  CONV_THRESH = 16'hFF00,
  parameter int                   NORM_CYCLES = 4,
  parameter int                   TIMEOUT     = 255
) (
  input  logic                clk_fast,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                fast_busy,
  input  logic                conv_valid,
  input  logic [METRIC_W-1:0] conv_metric,
  output logic                go_fast,
  output logic                en_norm,
  output logic                en_conv,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic                error,
  output logic [ITER_W-1:0]   iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_NORM, S_CONV, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               seen_busy_q, seen_busy_d;
  logic [7:0]         norm_cnt_q, norm_cnt_d;
  logic [ITER_W-1:0]  iter_q, iter_d, iter_inc;
  logic               conv_q, conv_d;
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
  logic               err_q, err_d;
  logic [7:0]         wd_q, wd_d;
`endif

  assign iter_inc = iter_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    norm_cnt_d  = norm_cnt_q;
    iter_d      = iter_q;
    conv_d      = conv_q;
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
    err_d       = err_q;
    wd_d        = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_RUN;
          seen_busy_d = 1'b0;
          iter_d      = '0;
          conv_d      = 1'b0;
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
          err_d       = 1'b0;
          wd_d        = '0;
`endif
        end
      end
      S_RUN: begin
        if (fast_busy) seen_busy_d = 1'b1;
        // busy having dropped after being seen means the pass reached SUB
        if (seen_busy_q && !fast_busy) begin
          state_d    = S_NORM;
          norm_cnt_d = '0;
        end
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
        else if (wd_q == 8'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          conv_d  = 1'b0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      S_NORM: begin
        if (norm_cnt_q == 8'(NORM_CYCLES - 1)) state_d = S_CONV;
        else norm_cnt_d = norm_cnt_q + 8'd1;
      end
      S_CONV: begin
        if (conv_valid) begin
          iter_d = iter_inc;
          if (conv_metric >= CONV_THRESH) begin
            conv_d  = 1'b1;
            state_d = S_DONE;
          end else if (iter_inc == ITER_W'(MAX_ITER)) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_RUN;
            seen_busy_d = 1'b0;
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
            wd_d        = '0;
`endif
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // cancel leaves result flags and count exactly as they were
    if (abort) begin
      state_d = S_IDLE;
      iter_d  = iter_q;
      conv_d  = conv_q;
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
      err_d   = err_q;
`endif
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seen_busy_q <= 1'b0;
      norm_cnt_q  <= '0;
      iter_q      <= '0;
      conv_q      <= 1'b0;
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
      err_q       <= 1'b0;
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      norm_cnt_q  <= norm_cnt_d;
      iter_q      <= iter_d;
      conv_q      <= conv_d;
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
      err_q       <= err_d;
      wd_q        <= wd_d;
`endif
    end
  end

  assign go_fast   = (state_q == S_RUN);
  assign en_norm   = (state_q == S_NORM);
  assign en_conv   = (state_q == S_CONV);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign converged = conv_q;
  assign iter_cnt  = iter_q;
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
  assign error     = err_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_one_unit_iter_controller.sv
// Randomised bench for one_unit_iter_controller against a transaction-level loop model.
module tb_one_unit_iter_controller;
  localparam int          MAX_ITER = 16;
  localparam int          PASS_LEN = 133;
  localparam int          NORM_LEN = 4;
  localparam logic [15:0] THRESH   = 16'hFF00;

  logic        clk_fast = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        fast_busy = 1'b0;
  logic        conv_valid = 1'b0;
  logic [15:0] conv_metric = 16'h0;
  logic        go_fast, en_norm, en_conv, busy, done, converged, error;
  logic [4:0]  iter_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk_fast = ~clk_fast;

  one_unit_iter_controller dut (
    .clk_fast   (clk_fast),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .fast_busy  (fast_busy),
    .conv_valid (conv_valid),
    .conv_metric(conv_metric),
    .go_fast    (go_fast),
    .en_norm    (en_norm),
    .en_conv    (en_conv),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .error      (error),
    .iter_cnt   (iter_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // one-unit fast controller model: INIT -> busy 131 cycles -> SUB
  int fm_st = 0;
  int fm_cnt = 0;
  bit stuck = 1'b0;
  always @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      fm_st <= 0; fast_busy <= 1'b0; fm_cnt <= 0;
    end else if (!go_fast) begin
      fm_st <= 0; fast_busy <= 1'b0;
    end else if (fm_st == 0) begin
      fm_st <= 1; fast_busy <= 1'b1; fm_cnt <= 130;
    end else if (fm_st == 1 && !stuck) begin
      if (fm_cnt == 0) begin
        fm_st <= 2; fast_busy <= 1'b0;
      end else fm_cnt <= fm_cnt - 1;
    end
  end

  // convergence datapath responder with random latency
  logic [15:0] mq[$];
  int wait_n = 0;
  int conv_budget = 1000;
  initial forever begin
    @(negedge clk_fast);
    conv_valid = 1'b0;
    if (rst) begin
      wait_n = 0;
    end else if (en_conv && conv_budget > 0) begin
      if (wait_n > 0) wait_n--;
      else begin
        conv_valid  = 1'b1;
        conv_metric = (mq.size() > 0) ? mq.pop_front() : 16'h0;
        conv_budget--;
        wait_n = $urandom_range(0, 3);
      end
    end else if (go_fast) begin
      conv_valid  = 1'($urandom % 2);
      conv_metric = 16'hFFFF;
    end
  end

  // pulse monitor
  int go_lens[$];
  int norm_lens[$];
  int go_len = 0;
  int norm_len = 0;
  int n_done = 0;
  initial forever begin
    @(negedge clk_fast);
    if (go_fast) go_len++;
    else if (go_len > 0) begin go_lens.push_back(go_len); go_len = 0; end
    if (en_norm) norm_len++;
    else if (norm_len > 0) begin norm_lens.push_back(norm_len); norm_len = 0; end
    if (done) n_done++;
  end

  task automatic clear_mon();
    go_lens.delete(); norm_lens.delete();
    go_len = 0; norm_len = 0; n_done = 0;
  endtask

  function automatic int bad_lens(input int q[$], input int exp);
    int bad = 0;
    foreach (q[i]) if (q[i] != exp) bad++;
    return bad;
  endfunction

  // loop model: stop on first metric >= threshold, else after MAX_ITER checks
  function automatic void predict(input logic [15:0] m[$], output int iters,
                                  output bit cv);
    iters = 0; cv = 1'b0;
    for (int k = 0; k < MAX_ITER; k++) begin
      iters = k + 1;
      if (m[k] >= THRESH) begin cv = 1'b1; break; end
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk_fast); start = 1'b1;
    @(negedge clk_fast); start = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [15:0] m[$],
                          input bit extra);
    int iters; bit cv; int cyc;
    predict(m, iters, cv);
    mq = m; conv_budget = 1000;
    @(negedge clk_fast); clear_mon();
    pulse_start();
    check({tag, "_go_rise"}, go_fast, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      start = extra && (cyc == 50);
      @(negedge clk_fast); cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_iter_cnt"}, iter_cnt, iters);
    check({tag, "_converged"}, converged, cv);
    check({tag, "_error"}, error, 0);
    @(negedge clk_fast);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_go_pulses"}, go_lens.size(), iters);
    check({tag, "_go_len_bad"}, bad_lens(go_lens, PASS_LEN), 0);
    check({tag, "_norm_pulses"}, norm_lens.size(), iters);
    check({tag, "_norm_len_bad"}, bad_lens(norm_lens, NORM_LEN), 0);
  endtask

  task automatic wait_conv(input string tag, input int k);
    int cyc = 0;
    while (!(en_conv && iter_cnt == 5'(k)) && cyc < 5000) begin
      @(negedge clk_fast); cyc++;
    end
    check({tag, "_reach_conv"}, en_conv, 1);
  endtask

  logic [15:0] m[$];

  initial begin
    repeat (3) @(negedge clk_fast);
    check("rst_outs", {go_fast, en_norm, en_conv, busy, done, converged, error}, 0);
    check("rst_iter", iter_cnt, 0);
    rst = 1'b0;

    m = {16'hFFF0};
    while (m.size() < 16) m.push_back(16'h0123);
    run_case("first", m, 1'b0);

    m.delete();
    repeat (16) m.push_back(16'h8000);
    run_case("noconv", m, 1'b0);

    m = {16'h8000, 16'hFEFF, 16'hFF00};
    while (m.size() < 16) m.push_back(16'h0);
    run_case("edge", m, 1'b0);

    for (int r = 0; r < 3; r++) begin
      m.delete();
      for (int k = 0; k < 16; k++)
        if ($urandom_range(0, 7) == 0) m.push_back(THRESH + 16'($urandom_range(0, 255)));
        else m.push_back(16'($urandom_range(0, 16'hFEFF)));
      run_case($sformatf("rand%0d", r), m, 1'b0);
    end

    // abort and start together in IDLE
    @(negedge clk_fast); start = 1'b1; abort = 1'b1;
    @(negedge clk_fast); start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);

    // abort during MEAN phase of the first pass
    @(negedge clk_fast); clear_mon();
    pulse_start();
    repeat (60) @(negedge clk_fast);
    abort = 1'b1;
    @(negedge clk_fast); abort = 1'b0;
    check("abort_go", go_fast, 0);
    check("abort_busy", busy, 0);
    repeat (200) @(negedge clk_fast);
    check("abort_no_done", n_done, 0);
    check("abort_no_norm", norm_lens.size(), 0);

    // abort in CONV keeps iter_cnt
    m.delete(); repeat (16) m.push_back(16'h1000);
    mq = m; conv_budget = 2;
    @(negedge clk_fast); clear_mon();
    pulse_start();
    wait_conv("abconv", 2);
    abort = 1'b1;
    @(negedge clk_fast); abort = 1'b0;
    check("abconv_busy", busy, 0);
    check("abconv_iter", iter_cnt, 2);
    check("abconv_conv", converged, 0);
    check("abconv_no_done", n_done, 0);

    m = {16'h2000, 16'hFF80};
    while (m.size() < 16) m.push_back(16'h0);
    run_case("restart_extra", m, 1'b1);

    // rst while in CONV
    mq = m; conv_budget = 1;
    pulse_start();
    wait_conv("rstconv", 1);
    rst = 1'b1;
    #1;
    check("rstconv_outs", {go_fast, en_norm, en_conv, busy, done, converged, error}, 0);
    check("rstconv_iter", iter_cnt, 0);
    @(negedge clk_fast); rst = 1'b0;

    stuck = 1'b1;
    @(negedge clk_fast); clear_mon();
    pulse_start();
`ifdef ONE_UNIT_ITER_WATCHDOG_EN
    begin
      int cyc = 0;
      while (done !== 1'b1 && cyc < 1000) begin
        @(negedge clk_fast); cyc++;
      end
    end
    check("wd_done", done, 1);
    check("wd_error", error, 1);
    check("wd_conv", converged, 0);
    check("wd_iter", iter_cnt, 0);
    @(negedge clk_fast);
    check("wd_go_len", (go_lens.size() > 0) ? go_lens[0] : 0, 255);
`else
    repeat (600) @(negedge clk_fast);
    check("nowd_go", go_fast, 1);
    check("nowd_error", error, 0);
    check("nowd_no_done", n_done, 0);
    abort = 1'b1;
    @(negedge clk_fast); abort = 1'b0;
    check("nowd_abort", busy, 0);
`endif
    stuck = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/one_unit_iter_controller.md
Name: one_unit_iter_controller

Overview:
- Initiator side of the one-unit fast handshake: drives go_fast into the one-unit fast controller and watches its fast_busy output to detect when the MUL/MEAN/SUB pass completes.
- Sequences the FastICA fixed-point iteration loop: one-unit pass, then weight normalisation, then convergence check, repeated until converged or MAX_ITER is reached.
- Sits above the one-unit fast controller in the fastica top level, in the clk_fast domain.

Parameters:
- MAX_ITER, 16: maximum one-unit iterations per start.
- ITER_W, 5: width of iter_cnt; must hold MAX_ITER.
- METRIC_W, 16: width of conv_metric, unsigned Q0.16 |w_new·w_old|.
- CONV_THRESH, 16'hFF00: converged when conv_metric >= CONV_THRESH.
- NORM_CYCLES, 4: cycles en_norm is held high per iteration (1..255).
- TIMEOUT, 255: watchdog limit in RUN cycles (only used with the optional feature).

Ports:
- clk_fast, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request; accepted only in IDLE.
- abort, input, 1: one-cycle cancel; honoured in any state.
- fast_busy, input, 1: busy flag from the one-unit fast controller.
- conv_valid, input, 1: conv_metric is valid this cycle; sampled only in CONV.
- conv_metric, input, METRIC_W: convergence metric.
- go_fast, output, 1: enable to the one-unit controller; low holds it in INIT.
- en_norm, output, 1: enable for the normalisation datapath.
- en_conv, output, 1: request to the convergence-metric datapath.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at end of run.
- converged, output, 1: result flag; held until next accepted start.
- error, output, 1: watchdog flag; held until next accepted start.
- iter_cnt, output, ITER_W: completed iterations; held until next accepted start.

Behaviour:
- Reset: state IDLE; all outputs 0, including iter_cnt and the internal counters.
- States: IDLE, RUN, NORM, CONV, DONE. Outputs decode from the state register: go_fast=RUN, en_norm=NORM, en_conv=CONV, done=DONE, busy=!IDLE.
- IDLE:
  - start & !abort → RUN.
  - On entry to RUN: clear iter_cnt, converged and error.
  - go_fast rises the cycle after start is sampled.
- RUN:
  - Internal seen_busy flag is cleared on entry and set when fast_busy=1.
  - When seen_busy & !fast_busy (controller in SUB) → NORM.
  - go_fast therefore falls the cycle after SUB is sampled.
  - Nominal pass: fast_busy is high for 131 cycles, NORM is entered 133 cycles after go_fast rises.
- NORM: hold en_norm for exactly NORM_CYCLES cycles, then → CONV.
- CONV:
  - Hold en_conv high and wait indefinitely for conv_valid.
  - On conv_valid, iter_cnt increments, then exactly one of:
    - conv_metric >= CONV_THRESH: converged<=1 → DONE.
    - else if iter_cnt+1 == MAX_ITER: → DONE, converged stays 0.
    - else: → RUN (next pass; go_fast re-rises the following cycle, giving at least one cycle of go_fast low between passes).
- DONE: single cycle → IDLE.
- abort:
  - From any non-IDLE state: → IDLE next edge; go_fast, en_norm and en_conv fall.
  - done is not pulsed; converged, error and iter_cnt keep their current values.
  - abort & start together in IDLE: abort wins, stay IDLE.
- Ignored inputs:
  - start outside IDLE.
  - conv_valid outside CONV.
  - fast_busy outside RUN.
- Comparison is unsigned and full-width, with no rounding.
- rst mid-run: immediate return to IDLE and all outputs 0, including go_fast. The async drop of go_fast resets the downstream controller.

Optional Feature:
- Macro: ONE_UNIT_ITER_WATCHDOG_EN.
- Defined:
  - An 8-bit RUN cycle counter clears on RUN entry.
  - If it reaches TIMEOUT while still in RUN: error<=1 → DONE, converged=0, iter_cnt unchanged.
- Undefined: no counter; RUN waits indefinitely; error is tied 0.

Test Plan:
- Convergence on first pass:
  - Stimulus: reset, start; behavioural controller model (131 busy cycles then SUB); conv_metric=16'hFFF0 on the first conv_valid.
  - Response: go_fast high 133 cycles, en_norm high exactly 4 cycles, one done pulse, converged=1, iter_cnt=1.
- No convergence:
  - Stimulus: conv_metric=16'h8000 on every check.
  - Response: 16 go_fast pulses, done with converged=0, iter_cnt=16, error=0.
- Threshold edge:
  - Stimulus: conv_metric exactly 16'hFF00 on the third check.
  - Response: converged=1, iter_cnt=3.
- Abort mid-pass:
  - Stimulus: abort during the MEAN phase.
  - Response: go_fast 0 next cycle, busy 0, no done, no en_norm. A later start runs normally with iter_cnt restarting at 0.
- Watchdog (macro defined):
  - Stimulus: fast_busy stuck 1.
  - Response: after 255 RUN cycles, go_fast 0, done pulse, error=1, converged=0. With the macro undefined, go_fast stays 1 indefinitely.
- Start while busy, and rst mid-CONV:
  - Stimulus: start during RUN; then rst asserted during CONV.
  - Response: the extra start has no effect; rst forces all outputs to 0 immediately.
